// File: rtl/sram_pump_pkg.sv
// Shared types for the SRAM pump writer: write-FSM states, the pending-write
// FIFO entry and the synchroniser depth.
package sram_pump_pkg;

    // Flops in each SCK->clk synchroniser (a history flop follows them).
    localparam int unsigned SYNC_STAGES = 2;

    // Address width carried in a FIFO entry; matches the pump address bus.
    localparam int unsigned PUMP_ADDR_W = 19;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [PUMP_ADDR_W-1:0] addr;
        logic [BYTE_W-1:0]      data;
    } fifo_entry_t;

endpackage

// File: rtl/pump_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending pump writes.
//   clk, reset_n     : clock, asynchronous active-low reset (flushes pointers)
//   push, push_data  : write an entry; ignored while full
//   pop,  pop_data   : pop_data shows the head entry; pop advances; ignored while empty
//   full, empty      : registered occupancy flags
// DEPTH must be a power of two, minimum 2.
module pump_fifo
    import sram_pump_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fifo_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sram_pump_writer.sv
// SRAM pump writer: turns SCK-domain pump byte strobes into timed SRAM write
// cycles in the clk domain, and muxes the external SRAM between the core and
// the pump (core held off via core_wait_o while the pump owns the SRAM).
//
// Ports:
//   clk, reset_n                  : system clock (>= 4x SCK), async active-low reset
//   pump_active_i/a_i/d_i/we_n_i  : pump handshake (SCK domain)
//   core_a_i/d_i/we_n_i/oe_n_i    : core SRAM request, passed through when idle
//   core_q_o                      : SRAM read data to the core
//   core_wait_o                   : registered; high while the pump owns the SRAM
//   sram_a_o/dq_o/dq_oe_o/dq_i    : SRAM address and data bus
//   sram_we_n_o/oe_n_o            : SRAM strobes
//   load_done_o                   : one-clk pulse when a finished load has drained
//   byte_count_o                  : bytes accepted in the current/last load (saturating)
//   overflow_o                    : sticky, a byte was dropped on a full FIFO
//   checksum_o                    : only with PUMP_CHECKSUM_EN; 16-bit sum of written bytes
//
// Build option: define PUMP_CHECKSUM_EN to add checksum_o.
// ADDR_W must not exceed PUMP_ADDR_W (width of the FIFO entry address).
module sram_pump_writer
    import sram_pump_pkg::*;
#(
    parameter int unsigned ADDR_W     = PUMP_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WE_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              pump_active_i,
    input  logic [ADDR_W-1:0] pump_a_i,
    input  logic [7:0]        pump_d_i,
    input  logic              pump_we_n_i,

    input  logic [ADDR_W-1:0] core_a_i,
    input  logic [7:0]        core_d_i,
    input  logic              core_we_n_i,
    input  logic              core_oe_n_i,
    output logic [7:0]        core_q_o,
    output logic              core_wait_o,

    output logic [ADDR_W-1:0] sram_a_o,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,

    output logic              load_done_o,
    output logic [ADDR_W:0]   byte_count_o,
    output logic              overflow_o
`ifdef PUMP_CHECKSUM_EN
    ,
    output logic [15:0]       checksum_o
`endif
);

    localparam int unsigned CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam int unsigned BC_W  = ADDR_W + 1;

    // ---------------------------------------------------------------
    // SCK-domain synchronisers with one history flop each
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] active_sync;
    logic [SYNC_STAGES-1:0] we_n_sync;
    logic                   active_hist;
    logic                   we_n_hist;
    logic                   sync_active;
    logic                   sync_we_n;
    logic                   active_rise;
    logic                   active_fall;
    logic                   wr_req;

    // we_n idles high, so its chain resets to 1 to avoid a false request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_sync <= '0;
            we_n_sync   <= '1;
            active_hist <= 1'b0;
            we_n_hist   <= 1'b1;
        end else begin
            active_sync <= {active_sync[SYNC_STAGES-2:0], pump_active_i};
            we_n_sync   <= {we_n_sync[SYNC_STAGES-2:0], pump_we_n_i};
            active_hist <= active_sync[SYNC_STAGES-1];
            we_n_hist   <= we_n_sync[SYNC_STAGES-1];
        end
    end

    assign sync_active = active_sync[SYNC_STAGES-1];
    assign sync_we_n   = we_n_sync[SYNC_STAGES-1];
    assign active_rise = sync_active & ~active_hist;
    assign active_fall = ~sync_active & active_hist;
    assign wr_req      = we_n_hist & ~sync_we_n;

    // ---------------------------------------------------------------
    // Pending-write FIFO; address/data sampled straight from the pump
    // pins in the request cycle (the pump holds them long enough).
    // ---------------------------------------------------------------
    fifo_entry_t push_entry;
    fifo_entry_t pop_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        push_ok;
    logic        drop;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = PUMP_ADDR_W'(pump_a_i);
        push_entry.data = pump_d_i;
    end

    assign push_ok = wr_req & ~fifo_full;
    assign drop    = wr_req & fifo_full;

    pump_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_req),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------------------------------------------------------
    // Write FSM: IDLE (pop) -> SETUP -> WRITE x WE_CYCLES -> HOLD
    // ---------------------------------------------------------------
    wr_state_e         state;
    wr_state_e         state_nxt;
    logic [CNT_W-1:0]  we_cnt;
    logic [CNT_W-1:0]  we_cnt_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            we_cnt  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state  <= state_nxt;
            we_cnt <= we_cnt_nxt;
            if (fifo_pop) begin
                wr_addr <= ADDR_W'(pop_entry.addr);
                wr_data <= pop_entry.data;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        we_cnt_nxt = we_cnt;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                we_cnt_nxt = CNT_W'(WE_CYCLES - 1);
                state_nxt  = WRITE;
            end
            WRITE: begin
                if (we_cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    we_cnt_nxt = we_cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // SRAM ownership mux; core passes through combinationally when idle.
    // ---------------------------------------------------------------
    logic pump_own;

    assign pump_own = sync_active | ~fifo_empty | (state != IDLE);
    assign core_q_o = sram_dq_i;

    always_comb begin
        sram_a_o     = core_a_i;
        sram_dq_o    = core_d_i;
        sram_dq_oe_o = ~core_we_n_i;
        sram_we_n_o  = core_we_n_i;
        sram_oe_n_o  = core_oe_n_i;
        if (pump_own) begin
            sram_a_o     = wr_addr;
            sram_dq_o    = wr_data;
            sram_dq_oe_o = (state != IDLE);
            sram_we_n_o  = (state != WRITE);
            sram_oe_n_o  = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Load status: ownership flag, byte count, overflow, done pulse
    // ---------------------------------------------------------------
    logic done_armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_wait_o  <= 1'b0;
            byte_count_o <= '0;
            overflow_o   <= 1'b0;
            done_armed   <= 1'b0;
            load_done_o  <= 1'b0;
        end else begin
            core_wait_o <= pump_own;
            load_done_o <= 1'b0;

            // A load start restarts the count; a coincident byte still counts.
            if (active_rise) begin
                byte_count_o <= BC_W'(push_ok);
                overflow_o   <= drop;
            end else begin
                if (push_ok && (byte_count_o != '1)) begin
                    byte_count_o <= byte_count_o + BC_W'(1);
                end
                if (drop) begin
                    overflow_o <= 1'b1;
                end
            end

            // Done fires once the load has ended and every byte is in SRAM.
            if (active_rise) begin
                done_armed <= 1'b0;
            end else if (active_fall) begin
                done_armed <= 1'b1;
            end else if (done_armed && fifo_empty && !push_ok && (state == IDLE)) begin
                done_armed  <= 1'b0;
                load_done_o <= 1'b1;
            end
        end
    end

`ifdef PUMP_CHECKSUM_EN
    // Running 16-bit sum of bytes actually written, updated as each write completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_o <= '0;
        end else if (active_rise) begin
            checksum_o <= '0;
        end else if (state == HOLD) begin
            checksum_o <= checksum_o + 16'(wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_sram_pump_writer.sv
// Self-checking bench for sram_pump_writer (default parameters).
// Define PUMP_CHECKSUM_EN to also exercise checksum_o.
module tb_sram_pump_writer;

    localparam int unsigned AW = 19;
    localparam int unsigned WE = 2;

    logic          clk;
    logic          reset_n;
    logic          pump_active_i;
    logic [AW-1:0] pump_a_i;
    logic [7:0]    pump_d_i;
    logic          pump_we_n_i;
    logic [AW-1:0] core_a_i;
    logic [7:0]    core_d_i;
    logic          core_we_n_i;
    logic          core_oe_n_i;
    logic [7:0]    core_q_o;
    logic          core_wait_o;
    logic [AW-1:0] sram_a_o;
    logic [7:0]    sram_dq_o;
    logic          sram_dq_oe_o;
    logic [7:0]    sram_dq_i;
    logic          sram_we_n_o;
    logic          sram_oe_n_o;
    logic          load_done_o;
    logic [AW:0]   byte_count_o;
    logic          overflow_o;
`ifdef PUMP_CHECKSUM_EN
    logic [15:0]   checksum_o;
`endif

    sram_pump_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pump_active_i (pump_active_i),
        .pump_a_i      (pump_a_i),
        .pump_d_i      (pump_d_i),
        .pump_we_n_i   (pump_we_n_i),
        .core_a_i      (core_a_i),
        .core_d_i      (core_d_i),
        .core_we_n_i   (core_we_n_i),
        .core_oe_n_i   (core_oe_n_i),
        .core_q_o      (core_q_o),
        .core_wait_o   (core_wait_o),
        .sram_a_o      (sram_a_o),
        .sram_dq_o     (sram_dq_o),
        .sram_dq_oe_o  (sram_dq_oe_o),
        .sram_dq_i     (sram_dq_i),
        .sram_we_n_o   (sram_we_n_o),
        .sram_oe_n_o   (sram_oe_n_o),
        .load_done_o   (load_done_o),
        .byte_count_o  (byte_count_o),
        .overflow_o    (overflow_o)
`ifdef PUMP_CHECKSUM_EN
        ,
        .checksum_o    (checksum_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    len;
        logic          setup_ok;
        logic          hold_ok;
    } wr_t;

    wr_t           obs_q[$];
    logic [AW-1:0] sent_a[$];
    logic [7:0]    sent_d[$];
    int            done_cnt = 0;

    // Bus monitor: records every completed SRAM write as seen on the pins.
    int            run_len = 0;
    logic [AW-1:0] cur_a, prev_a;
    logic [7:0]    cur_d, prev_d;
    logic          cur_setup, cur_stable, prev_we, prev_oe;

    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else if (sram_we_n_o === 1'b0) begin
            if (run_len == 0) begin
                cur_a      = sram_a_o;
                cur_d      = sram_dq_o;
                cur_setup  = (prev_we === 1'b1) && (prev_oe === 1'b1) &&
                             (prev_a === sram_a_o) && (prev_d === sram_dq_o);
                cur_stable = 1'b1;
            end else if (sram_a_o !== cur_a || sram_dq_o !== cur_d) begin
                cur_stable = 1'b0;
            end
            if (sram_dq_oe_o !== 1'b1) cur_stable = 1'b0;
            run_len++;
        end else if (run_len != 0) begin
            obs_q.push_back('{a: cur_a, d: cur_d, len: 8'(run_len), setup_ok: cur_setup,
                              hold_ok: cur_stable && (sram_dq_oe_o === 1'b1) &&
                                       (sram_a_o === cur_a) && (sram_dq_o === cur_d)});
            run_len = 0;
        end
        if (reset_n && load_done_o === 1'b1) done_cnt++;
        prev_we = sram_we_n_o;
        prev_oe = sram_dq_oe_o;
        prev_a  = sram_a_o;
        prev_d  = sram_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pump strobe: we_n low for lo clks then high for hi clks, addr/data held throughout.
    task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d, input int lo, input int hi);
        pump_a_i    = a;
        pump_d_i    = d;
        pump_we_n_i = 1'b0;
        repeat (lo) @(negedge clk);
        pump_we_n_i = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic wait_done(input int base, output bit got);
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (done_cnt != base) got = 1'b1;
        end
    endtask

    // Full load of sent_a/sent_d; core tries to write meanwhile and must be ignored.
    task automatic run_load(input string tag, input int lo, input int hi, input bit expect_all);
        int  base;
        bit  got;
        int  j;
        bit  in_order;
        int  n;
        n = sent_a.size();
        obs_q.delete();
        pump_active_i = 1'b1;
        repeat (4) @(negedge clk);
        check($sformatf("%s_count_clear", tag), byte_count_o, 0);
        check($sformatf("%s_ovf_clear", tag), overflow_o, 0);
        check($sformatf("%s_wait_hi", tag), core_wait_o, 1);
        core_a_i    = AW'($urandom);
        core_d_i    = 8'($urandom);
        core_we_n_i = 1'b0;
        for (int i = 0; i < n; i++) send_byte(sent_a[i], sent_d[i], lo, hi);
        core_we_n_i = 1'b1;
        repeat (12) @(negedge clk);
        base = done_cnt;
        pump_active_i = 1'b0;
        wait_done(base, got);
        check($sformatf("%s_done_seen", tag), 32'(got), 1);
        repeat (4) @(negedge clk);
        check($sformatf("%s_done_once", tag), done_cnt - base, 1);
        check($sformatf("%s_wait_lo", tag), core_wait_o, 0);
        if (expect_all) begin
            check($sformatf("%s_count", tag), byte_count_o, n);
            check($sformatf("%s_ovf", tag), overflow_o, 0);
            check($sformatf("%s_nwrites", tag), obs_q.size(), n);
            for (int i = 0; i < n && i < obs_q.size(); i++) begin
                check($sformatf("%s_w%0d", tag, i),
                      {obs_q[i].a, obs_q[i].d, obs_q[i].len[3:0], obs_q[i].setup_ok, obs_q[i].hold_ok},
                      {sent_a[i], sent_d[i], 4'(WE), 1'b1, 1'b1});
            end
        end else begin
            check($sformatf("%s_ovf", tag), overflow_o, 1);
            check($sformatf("%s_count_vs_writes", tag), byte_count_o, obs_q.size());
            check($sformatf("%s_some_dropped", tag), 32'(obs_q.size() < n), 1);
            j = 0;
            in_order = 1'b1;
            for (int i = 0; i < obs_q.size(); i++) begin
                while (j < n && !(sent_a[j] == obs_q[i].a && sent_d[j] == obs_q[i].d)) j++;
                if (j >= n || obs_q[i].len != 8'(WE)) in_order = 1'b0;
                j++;
            end
            check($sformatf("%s_subseq", tag), 32'(in_order), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            got;
        int            base;
        int            n;
        logic [15:0]   sum;
        logic [7:0]    rd;

        reset_n       = 1'b0;
        pump_active_i = 1'b0;
        pump_a_i      = '0;
        pump_d_i      = '0;
        pump_we_n_i   = 1'b1;
        core_a_i      = '0;
        core_d_i      = '0;
        core_we_n_i   = 1'b1;
        core_oe_n_i   = 1'b1;
        sram_dq_i     = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_we_n", sram_we_n_o, 1);
        check("rst_oe_n", sram_oe_n_o, 1);
        check("rst_dq_oe", sram_dq_oe_o, 0);
        check("rst_wait", core_wait_o, 0);
        check("rst_done", load_done_o, 0);
        check("rst_count", byte_count_o, 0);
        check("rst_ovf", overflow_o, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Three directed bytes at SCK = clk/8
        sent_a = '{19'h00000, 19'h00001, 19'h00002};
        sent_d = '{8'hA5, 8'h5A, 8'hFF};
        run_load("dir3", 4, 4, 1'b1);

        // Randomised loads at slow SCK, one with the address wrap
        for (int t = 0; t < 4; t++) begin
            sent_a.delete();
            sent_d.delete();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                sent_a.push_back(AW'($urandom));
                sent_d.push_back(8'($urandom));
            end
            if (t == 1) begin
                sent_a.push_back(19'h7FFFF);
                sent_d.push_back(8'($urandom));
                sent_a.push_back(19'h00000);
                sent_d.push_back(8'($urandom));
            end
            run_load($sformatf("rnd%0d", t), 4, 4, 1'b1);
        end

        // Burst faster than the drain rate: bytes are dropped
        sent_a.delete();
        sent_d.delete();
        for (int i = 0; i < 16; i++) begin
            sent_a.push_back(AW'(i + 32'h100));
            sent_d.push_back(8'($urandom));
        end
        run_load("burst", 1, 2, 1'b0);

        // Next load clears the overflow flag
        sent_a = '{AW'($urandom), AW'($urandom)};
        sent_d = '{8'($urandom), 8'($urandom)};
        run_load("after_ovf", 4, 4, 1'b1);

        // Active drops and rises again before drain: no done pulse, count restarts
        sent_a = '{19'h00010, 19'h00011, 19'h00012};
        sent_d = '{8'h11, 8'h22, 8'h33};
        obs_q.delete();
        pump_active_i = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) send_byte(sent_a[i], sent_d[i], 1, 2);
        base = done_cnt;
        pump_active_i = 1'b0;
        repeat (2) @(negedge clk);
        pump_active_i = 1'b1;
        repeat (6) @(negedge clk);
        check("toggle_count_restart", byte_count_o, 0);
        repeat (60) @(negedge clk);
        check("toggle_no_done", done_cnt - base, 0);
        check("toggle_writes", obs_q.size(), 3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++)
            check($sformatf("toggle_w%0d", i), {obs_q[i].a, obs_q[i].d}, {sent_a[i], sent_d[i]});
        pump_active_i = 1'b0;
        wait_done(base, got);
        check("toggle_final_done", 32'(got), 1);
        check("toggle_final_count", byte_count_o, 0);
        repeat (4) @(negedge clk);

`ifdef PUMP_CHECKSUM_EN
        // 300 x 0xFF: sum 76500 = 0x12AD4, kept to 16 bits
        sent_a.delete();
        sent_d.delete();
        sum = '0;
        for (int i = 0; i < 300; i++) begin
            sent_a.push_back(AW'(i));
            sent_d.push_back(8'hFF);
            sum = sum + 16'hFF;
        end
        run_load("csum", 4, 4, 1'b1);
        check("csum_model", 32'(sum), 32'h2AD4);
        check("csum_value", checksum_o, 32'(sum));
`endif

        // Reset asserted mid-WRITE with a second byte still queued
        obs_q.delete();
        base = done_cnt;
        pump_active_i = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(19'h00ABC, 8'hC3, 1, 2);
        send_byte(19'h00ABD, 8'h3C, 1, 2);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (sram_we_n_o === 1'b0) got = 1'b1;
            else @(negedge clk);
        end
        check("rstmid_reached_write", 32'(got), 1);
        core_a_i = 19'h0F0F0;
        #2;
        reset_n       = 1'b0;
        pump_active_i = 1'b0;
        #1;
        check("rstmid_we_n", sram_we_n_o, 1);
        check("rstmid_dq_oe", sram_dq_oe_o, 0);
        check("rstmid_released_bus", sram_a_o, 32'h0F0F0);
        check("rstmid_wait", core_wait_o, 0);
        check("rstmid_count", byte_count_o, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        repeat (40) @(negedge clk);
        check("rstmid_no_write", obs_q.size(), 0);
        check("rstmid_no_done", done_cnt - base, 0);
        check("rstmid_idle_wait", core_wait_o, 0);

        // Core passthrough with the pump idle
        @(negedge clk);
        core_a_i    = 19'h12345;
        core_d_i    = 8'h3C;
        core_we_n_i = 1'b0;
        core_oe_n_i = 1'b1;
        rd          = 8'($urandom);
        sram_dq_i   = rd;
        #1;
        check("core_a", sram_a_o, 32'h12345);
        check("core_dq", sram_dq_o, 32'h3C);
        check("core_dq_oe", sram_dq_oe_o, 1);
        check("core_we_n", sram_we_n_o, 0);
        check("core_wait", core_wait_o, 0);
        check("core_q", core_q_o, 32'(rd));
        @(negedge clk);
        core_we_n_i = 1'b1;
        core_oe_n_i = 1'b0;
        #1;
        check("core_rd_dq_oe", sram_dq_oe_o, 0);
        check("core_rd_oe_n", sram_oe_n_o, 0);
        core_oe_n_i = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
